// File: rtl/pad_share_arbiter.sv
// Round-robin owner arbitration for a shared bank of bidirectional pads, with a tri-state
// turnaround gap between owners and a synchronised return path for pad input data.
module pad_share_arbiter #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned PadWidth   = 4,
    parameter int unsigned TurnCycles = 2,
    parameter int unsigned SyncStages = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [NumReq-1:0]            req_i,
    output logic [NumReq-1:0]            gnt_o,
    input  logic [NumReq*PadWidth-1:0]   oe_i,
    input  logic [NumReq*PadWidth-1:0]   out_i,
    output logic [NumReq*PadWidth-1:0]   in_o,
    output logic [PadWidth-1:0]          pad_oen_o,
    output logic [PadWidth-1:0]          pad_out_o,
    input  logic [PadWidth-1:0]          pad_in_i,
    output logic                         busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]     sel;
    logic [IdxW-1:0]     cand;
    logic                found;
    logic [PadWidth-1:0] sync_data;

    // First requester at or above the RR pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NumReq);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (en_i && found) begin
                    state_d = StGrant;
                    owner_d = sel;
                    gnt_d   = NumReq'(1) << sel;
                    ptr_d   = (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
                end
            end
            StGrant: begin
                if (!req_i[owner_q]) begin
                    gnt_d = '0;
                    if (TurnCycles > 0) begin
                        state_d = StTurn;
                        cnt_d   = CntW'(TurnCycles - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    generate
        if (SyncStages == 0) begin : g_bypass
            assign sync_data = pad_in_i;
        end else begin : g_sync
            logic [PadWidth-1:0] sync_q [SyncStages];
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= pad_in_i;
                    for (int unsigned i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign sync_data = sync_q[SyncStages-1];
        end
    endgenerate

    // Pads are driven only while a grant is registered; everything else is high-Z.
    always_comb begin
        pad_oen_o = '1;
        pad_out_o = '0;
        in_o      = '0;
        if (|gnt_q) begin
            pad_oen_o = ~oe_i[32'(owner_q)*PadWidth +: PadWidth];
            pad_out_o = out_i[32'(owner_q)*PadWidth +: PadWidth];
            in_o[32'(owner_q)*PadWidth +: PadWidth] = sync_data;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = (state_q != StIdle);

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_q));
    a_idle_hiz: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (gnt_q == '0) |-> (pad_oen_o == '1));
    a_no_direct_switch: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((gnt_q != '0) && ($past(gnt_q) != '0)) |-> (gnt_q == $past(gnt_q)));

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Bench for pad_share_arbiter: directed stimulus, per-cycle comparison against an
// ownership/gap model, plus literal expectations at key points.
module tb_pad_share_arbiter;

    localparam int N  = 3;
    localparam int W  = 4;
    localparam int TC = 2;
    localparam int SS = 2;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N*W-1:0] oe;
    logic [N*W-1:0] out_d;
    logic [N*W-1:0] in_d;
    logic [W-1:0]   pad_oen;
    logic [W-1:0]   pad_out;
    logic [W-1:0]   pad_in;
    logic           busy;

    always #5 clk = ~clk;

    pad_share_arbiter #(
        .NumReq     (N),
        .PadWidth   (W),
        .TurnCycles (TC),
        .SyncStages (SS)
    ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (en),
        .req_i     (req),
        .gnt_o     (gnt),
        .oe_i      (oe),
        .out_i     (out_d),
        .in_o      (in_d),
        .pad_oen_o (pad_oen),
        .pad_out_o (pad_out),
        .pad_in_i  (pad_in),
        .busy_o    (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: current owner (-1 = none), cycles of tri-state gap still to serve,
    // RR pointer, and the pad input history seen by the owner.
    int          m_owner = -1;
    int          m_turn  = 0;
    int          m_ptr   = 0;
    int          m_c;
    logic [W-1:0] m_pin[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1;
            m_turn  = 0;
            m_ptr   = 0;
            m_pin.delete();
            for (int k = 0; k < SS; k++) m_pin.push_front('0);
        end else begin
            if (m_owner >= 0) begin
                if (!req[IW'(m_owner)]) begin
                    m_owner = -1;
                    m_turn  = TC;
                end
            end else if (m_turn > 0) begin
                m_turn--;
            end else if (en && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (req[IW'(m_c)]) begin
                        m_owner = m_c;
                        m_ptr   = (m_c + 1) % N;
                        break;
                    end
                end
            end
            m_pin.push_front(pad_in);
            void'(m_pin.pop_back());
        end
    end

    logic [N-1:0]   e_gnt;
    logic [W-1:0]   e_oen;
    logic [W-1:0]   e_out;
    logic [N*W-1:0] e_in;
    logic           e_busy;

    always @(negedge clk) begin
        if (cmp_on) begin
            e_gnt  = '0;
            e_oen  = '1;
            e_out  = '0;
            e_in   = '0;
            e_busy = (m_owner >= 0) || (m_turn > 0);
            if (m_owner >= 0) begin
                e_gnt[IW'(m_owner)] = 1'b1;
                e_oen = ~oe[m_owner*W +: W];
                e_out = out_d[m_owner*W +: W];
                e_in[m_owner*W +: W] = m_pin[SS-1];
            end
            chk("cyc_gnt", 32'(gnt), 32'(e_gnt));
            chk("cyc_pad_oen", 32'(pad_oen), 32'(e_oen));
            chk("cyc_pad_out", 32'(pad_out), 32'(e_out));
            chk("cyc_in", 32'(in_d), 32'(e_in));
            chk("cyc_busy", 32'(busy), 32'(e_busy));
        end
    end

    int ord [4] = '{0, 1, 2, 0};
    int cyc;

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        req    = 3'b011;
        oe     = '0;
        out_d  = '0;
        pad_in = '0;
        step(1);
        cmp_on = 1'b1;
        step(2);

        // Reset held with requests pending
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_oen", 32'(pad_oen), 32'hF);
        chk("rst_pout", 32'(pad_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_gnt", 32'(gnt), 32'h1);

        // Owner 0 drives; requester 1 values must be ignored
        oe[3:0]    = 4'b0101;
        out_d[3:0] = 4'hF;
        oe[7:4]    = 4'hF;
        out_d[7:4] = 4'hA;
        pad_in     = 4'h9;
        #1;
        chk("drive_oen", 32'(pad_oen), 32'hA);
        chk("drive_out", 32'(pad_out), 32'hF);
        @(negedge clk);
        chk("sync_1edge", 32'(in_d[3:0]), 32'h0);
        @(negedge clk);
        chk("sync_2edge", 32'(in_d[3:0]), 32'h9);
        chk("sync_other", 32'(in_d[7:4]), 32'h0);

        // Handoff 0 -> 1 with turnaround gap
        req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gap_gnt", 32'(gnt), 32'h0);
            chk("gap_oen", 32'(pad_oen), 32'hF);
        end
        @(negedge clk);
        chk("handoff_gnt", 32'(gnt), 32'h2);
        chk("handoff_oen", 32'(pad_oen), 32'h0);
        chk("handoff_out", 32'(pad_out), 32'hA);
        chk("handoff_in", 32'(in_d[7:4]), 32'h9);
        req = 3'b000;
        step(4);

        // en_i gating
        en  = 1'b0;
        req = 3'b001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_block", 32'(gnt), 32'h0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_grant", 32'(gnt), 32'h1);
        en      = 1'b0;
        oe[3:0] = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_hold", 32'(gnt), 32'h1);
        end
        chk("own_drive_oen", 32'(pad_oen), 32'h0);

        // Reset in GRANT: pads released at once, pointer back to 0
        rst_n = 1'b0;
        req   = 3'b011;
        en    = 1'b1;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_oen", 32'(pad_oen), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ptr", 32'(gnt), 32'h1);

        // Round-robin with immediate re-request by each releaser
        req         = 3'b111;
        pad_in      = 4'h6;
        oe[11:8]    = 4'hC;
        out_d[11:8] = 4'h3;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (gnt == '0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("rr_order", 32'(gnt), 32'(1) << ord[k]);
            repeat (3) @(negedge clk);
            req[IW'(ord[k])] = 1'b0;
            @(negedge clk);
            req[IW'(ord[k])] = 1'b1;
        end
        req = 3'b000;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
